// File: rtl/im_program_loader.sv
// im_program_loader: boot-time instruction memory writer packing a byte stream into big-endian words
//   CLK/RST            clock, asynchronous active-low reset
//   Start, Word_Count  begin a load of Word_Count words (sampled in IDLE/DONE)
//   Byte_In/Valid/Ready byte stream handshake
//   IM_Write_*         one-cycle instruction memory write port
//   Core_Hold, Busy, Done, Error  status
//   Optional macro LOADER_CHECKSUM_EN: trailing XOR checksum byte verified before release
module im_program_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Word_Count,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  IM_Write_Enable,
    output logic [ADDR_WIDTH-1:0] IM_Write_Addr,
    output logic [31:0]           IM_Write_Data,
    output logic                  Core_Hold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d, wc_q, wc_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           word_q, word_d;
    logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    localparam state_t LAST = CHECK;
`else
    localparam state_t LAST = DONE;
`endif
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            widx_q  <= '0;
            wc_q    <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            wc_q    <= wc_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        wc_d    = wc_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE, DONE: if (Start) begin
                if (Word_Count > DEPTH) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b0;
                    wc_d    = Word_Count;
                    widx_d  = '0;
                    bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (Word_Count == '0) ? DONE : RECV;
                end
            end
            // shifting in from the right leaves byte 0 in the top lane after four transfers
            RECV: if (Byte_Valid) begin
                word_d = {word_q[23:0], Byte_In};
                bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum_d = csum_q ^ Byte_In;
`endif
                if (bcnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                widx_d  = widx_q + (ADDR_WIDTH+1)'(1);
                bcnt_d  = '0;
                state_d = (widx_d == wc_q) ? LAST : RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (Byte_Valid) begin
                err_d   = Byte_In != csum_q;
                state_d = (Byte_In == csum_q) ? DONE : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    assign Byte_Ready      = state_q == RECV
`ifdef LOADER_CHECKSUM_EN
                             || state_q == CHECK
`endif
                             ;
    assign IM_Write_Enable = state_q == WRITE;
    assign IM_Write_Addr   = widx_q[ADDR_WIDTH-1:0];
    assign IM_Write_Data   = word_q;
    assign Core_Hold       = state_q != DONE;
    assign Done            = state_q == DONE;
    assign Busy            = state_q != IDLE && state_q != DONE;
    assign Error           = err_q;
endmodule
